// File: rtl/rename_stage_nw.sv
// rename_stage_nw
// ---------------
// N-wide register-rename stage sitting between decode and dispatch.
// Each accepted bundle has its architectural sources mapped to physical
// registers. Each allocating lane takes a new destination from a circular
// free list. Dependencies inside the bundle are forwarded from lower lanes.
//
// The stage keeps two map tables:
//   - a speculative map, updated on rename;
//   - a committed map, updated on retire.
// A recover restores the speculative map and the speculative free-list head
// from the committed copies in a single cycle.
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   recover             flush speculative state back to committed state
//   in_valid/in_ready   rename bundle handshake
//   in_lane_valid       per-lane valid
//   in_src0/src1/dst    architectural addresses, lane i at [i*AW +: AW]
//   in_dst_we           lane writes its destination
//   out_valid/out_ready registered output slot handshake
//   out_lane_valid      per-lane valid, passed through
//   out_src0_p/src1_p   renamed sources
//   out_dst_p           newly allocated destination (0 if lane does not allocate)
//   out_stale_p         previous mapping of the destination (0 if no allocation)
//   commit_valid/we     per-lane retire
//   commit_dst          retiring architectural destination
//   commit_dst_p        retiring new physical register
//   commit_stale_p      retiring stale physical register, returned to free list
//   free_count          speculative free-list occupancy
module rename_stage_nw #(
    parameter int WIDTH     = 2,
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 64,
    localparam int AW = $clog2(ARCH_REGS),
    localparam int PW = $clog2(PHYS_REGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                recover,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_lane_valid,
    input  logic [WIDTH*AW-1:0] in_src0,
    input  logic [WIDTH*AW-1:0] in_src1,
    input  logic [WIDTH*AW-1:0] in_dst,
    input  logic [WIDTH-1:0]    in_dst_we,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_lane_valid,
    output logic [WIDTH*PW-1:0] out_src0_p,
    output logic [WIDTH*PW-1:0] out_src1_p,
    output logic [WIDTH*PW-1:0] out_dst_p,
    output logic [WIDTH*PW-1:0] out_stale_p,
    input  logic [WIDTH-1:0]    commit_valid,
    input  logic [WIDTH-1:0]    commit_we,
    input  logic [WIDTH*AW-1:0] commit_dst,
    input  logic [WIDTH*PW-1:0] commit_dst_p,
    input  logic [WIDTH*PW-1:0] commit_stale_p,
    output logic [PW:0]         free_count
);
    localparam int FL_DEPTH = PHYS_REGS - ARCH_REGS;
    localparam int FLW      = $clog2(FL_DEPTH);
    localparam int PTRW     = FLW + 1;   // extra MSB is the wrap bit
    localparam logic [PTRW-1:0] PTR_ONE   = {{(PTRW-1){1'b0}}, 1'b1};
    localparam logic [PW:0]     WIDTH_CNT = WIDTH[PW:0];

    // Free list and map tables. Reset needs known contents, so these are
    // plain register arrays rather than block RAM.
    logic [PW-1:0]   fl_mem     [FL_DEPTH];
    logic [PW-1:0]   spec_map   [ARCH_REGS];
    logic [PW-1:0]   commit_map [ARCH_REGS];
    logic [PTRW-1:0] spec_head_reg, commit_head_reg, tail_reg;

    logic                out_valid_reg;
    logic [WIDTH-1:0]    out_lane_valid_reg;
    logic [WIDTH*PW-1:0] out_src0_reg, out_src1_reg, out_dst_reg, out_stale_reg;

    // Unpacked per-lane views of the buses.
    logic [AW-1:0] src0_a [WIDTH];
    logic [AW-1:0] src1_a [WIDTH];
    logic [AW-1:0] dst_a  [WIDTH];
    logic [AW-1:0] cdst_a [WIDTH];
    logic [PW-1:0] cdp_a  [WIDTH];
    logic [PW-1:0] cst_a  [WIDTH];
    logic [WIDTH-1:0] alloc, commit_ok;

    // Rename results.
    logic [PW-1:0] new_p   [WIDTH];
    logic [PW-1:0] src0_p  [WIDTH];
    logic [PW-1:0] src1_p  [WIDTH];
    logic [PW-1:0] dst_p   [WIDTH];
    logic [PW-1:0] stale_p [WIDTH];
    logic [WIDTH*PW-1:0] ren_src0, ren_src1, ren_dst, ren_stale;
    logic [PTRW-1:0] alloc_cnt, commit_cnt;
    logic [FLW-1:0]  cwr_idx [WIDTH];
    logic [PTRW-1:0] free_cnt_w;
    logic            fire;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_lane
            assign src0_a[gi] = in_src0[gi*AW +: AW];
            assign src1_a[gi] = in_src1[gi*AW +: AW];
            assign dst_a[gi]  = in_dst[gi*AW +: AW];
            assign cdst_a[gi] = commit_dst[gi*AW +: AW];
            assign cdp_a[gi]  = commit_dst_p[gi*PW +: PW];
            assign cst_a[gi]  = commit_stale_p[gi*PW +: PW];
            assign alloc[gi]     = in_lane_valid[gi] & in_dst_we[gi] & (dst_a[gi] != '0);
            assign commit_ok[gi] = commit_valid[gi] & commit_we[gi] & (cdst_a[gi] != '0);
            assign ren_src0[gi*PW +: PW]  = src0_p[gi];
            assign ren_src1[gi*PW +: PW]  = src1_p[gi];
            assign ren_dst[gi*PW +: PW]   = dst_p[gi];
            assign ren_stale[gi*PW +: PW] = stale_p[gi];
        end
    endgenerate

    assign free_cnt_w = tail_reg - spec_head_reg;
    assign free_count = {{(PW+1-PTRW){1'b0}}, free_cnt_w};
    // Frees from this cycle's commits are deliberately not bypassed here.
    assign in_ready   = rst & ~recover & (free_count >= WIDTH_CNT) & (~out_valid_reg | out_ready);
    assign fire       = in_valid & in_ready;

    // Allocation: allocating lanes take consecutive free-list slots in lane order.
    always_comb begin
        alloc_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            new_p[i] = fl_mem[spec_head_reg[FLW-1:0] + alloc_cnt[FLW-1:0]];
            if (alloc[i]) alloc_cnt = alloc_cnt + PTR_ONE;
        end
    end

    // Source/stale lookup. Later lower lanes override earlier ones, so the
    // newest matching writer below lane i wins.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            src0_p[i]  = spec_map[src0_a[i]];
            src1_p[i]  = spec_map[src1_a[i]];
            stale_p[i] = spec_map[dst_a[i]];
            for (int j = 0; j < WIDTH; j++) begin
                if (j < i && alloc[j]) begin
                    if (dst_a[j] == src0_a[i]) src0_p[i]  = new_p[j];
                    if (dst_a[j] == src1_a[i]) src1_p[i]  = new_p[j];
                    if (dst_a[j] == dst_a[i])  stale_p[i] = new_p[j];
                end
            end
            if (src0_a[i] == '0) src0_p[i] = '0;
            if (src1_a[i] == '0) src1_p[i] = '0;
            if (alloc[i]) begin
                dst_p[i] = new_p[i];
            end else begin
                dst_p[i]   = '0;
                stale_p[i] = '0;
            end
        end
    end

    // Tail slots written by this cycle's retiring lanes, in lane order.
    always_comb begin
        commit_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cwr_idx[i] = tail_reg[FLW-1:0] + commit_cnt[FLW-1:0];
            if (commit_ok[i]) commit_cnt = commit_cnt + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            spec_head_reg   <= '0;
            commit_head_reg <= '0;
            tail_reg        <= PTRW'(FL_DEPTH);
            for (int k = 0; k < FL_DEPTH; k++) fl_mem[k] <= PW'(ARCH_REGS + k);
            for (int k = 0; k < ARCH_REGS; k++) begin
                spec_map[k]   <= PW'(k);
                commit_map[k] <= PW'(k);
            end
            out_valid_reg      <= 1'b0;
            out_lane_valid_reg <= '0;
            out_src0_reg       <= '0;
            out_src1_reg       <= '0;
            out_dst_reg        <= '0;
            out_stale_reg      <= '0;
        end else begin
            // Retire: update committed map and return stale regs at the tail.
            for (int i = 0; i < WIDTH; i++) begin
                if (commit_ok[i]) begin
                    commit_map[cdst_a[i]] <= cdp_a[i];
                    fl_mem[cwr_idx[i]]    <= cst_a[i];
                end
            end
            tail_reg        <= tail_reg + commit_cnt;
            commit_head_reg <= commit_head_reg + commit_cnt;

            if (recover) begin
                // Copy the committed map, then overlay this cycle's commits
                // (later non-blocking writes take precedence).
                spec_head_reg <= commit_head_reg + commit_cnt;
                for (int k = 0; k < ARCH_REGS; k++) spec_map[k] <= commit_map[k];
                for (int i = 0; i < WIDTH; i++) begin
                    if (commit_ok[i]) spec_map[cdst_a[i]] <= cdp_a[i];
                end
                out_valid_reg <= 1'b0;
            end else if (fire) begin
                spec_head_reg <= spec_head_reg + alloc_cnt;
                for (int i = 0; i < WIDTH; i++) begin
                    if (alloc[i]) spec_map[dst_a[i]] <= new_p[i];
                end
                out_valid_reg      <= 1'b1;
                out_lane_valid_reg <= in_lane_valid;
                out_src0_reg       <= ren_src0;
                out_src1_reg       <= ren_src1;
                out_dst_reg        <= ren_dst;
                out_stale_reg      <= ren_stale;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid      = out_valid_reg;
    assign out_lane_valid = out_lane_valid_reg;
    assign out_src0_p     = out_src0_reg;
    assign out_src1_p     = out_src1_reg;
    assign out_dst_p      = out_dst_reg;
    assign out_stale_p    = out_stale_reg;

endmodule

// File: tb/tb_rename_stage_nw.sv
// Bench for rename_stage_nw: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a sequential
// rename model (map arrays + free-register queue + in-order retire queue).
module tb_rename_stage_nw;
    localparam int W  = 2;
    localparam int A  = 32;
    localparam int P  = 64;
    localparam int AW = 5;
    localparam int PW = 6;
    localparam int FL = P - A;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, recover, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0]    in_lane_valid, in_dst_we, out_lane_valid, commit_valid, commit_we;
    logic [W*AW-1:0] in_src0, in_src1, in_dst, commit_dst;
    logic [W*PW-1:0] out_src0_p, out_src1_p, out_dst_p, out_stale_p;
    logic [W*PW-1:0] commit_dst_p, commit_stale_p;
    logic [PW:0]     free_count;

    rename_stage_nw #(.WIDTH(W), .ARCH_REGS(A), .PHYS_REGS(P)) dut (
        .clk(clk), .rst(rst), .recover(recover),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_lane_valid(in_lane_valid), .in_src0(in_src0), .in_src1(in_src1),
        .in_dst(in_dst), .in_dst_we(in_dst_we),
        .out_valid(out_valid), .out_ready(out_ready), .out_lane_valid(out_lane_valid),
        .out_src0_p(out_src0_p), .out_src1_p(out_src1_p),
        .out_dst_p(out_dst_p), .out_stale_p(out_stale_p),
        .commit_valid(commit_valid), .commit_we(commit_we), .commit_dst(commit_dst),
        .commit_dst_p(commit_dst_p), .commit_stale_p(commit_stale_p),
        .free_count(free_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- behavioural model ----------------
    typedef struct { int dst; int p; int stale; } rob_t;
    int   m_spec [A];
    int   m_commit [A];
    int   ring [$];       // free regs from the committed head up to the tail
    int   spec_used;      // how many of ring[] are speculatively handed out
    bit   m_ov;
    int   m_lv [W];
    int   m_s0 [W];
    int   m_s1 [W];
    int   m_d  [W];
    int   m_st [W];
    rob_t rob [$];        // renamed, not yet retired (drives commit stimulus)

    function automatic int get_a(input logic [W*AW-1:0] v, input int i);
        return int'(v[i*AW +: AW]);
    endfunction

    function automatic int get_p(input logic [W*PW-1:0] v, input int i);
        return int'(v[i*PW +: PW]);
    endfunction

    function automatic bit m_in_ready();
        return rst && !recover && (ring.size() - spec_used >= W) && (!m_ov || out_ready);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < A; k++) begin
            m_spec[k]   = k;
            m_commit[k] = k;
        end
        ring.delete();
        for (int k = 0; k < FL; k++) ring.push_back(A + k);
        spec_used = 0;
        m_ov = 1'b0;
        for (int i = 0; i < W; i++) begin
            m_lv[i] = 0; m_s0[i] = 0; m_s1[i] = 0; m_d[i] = 0; m_st[i] = 0;
        end
        rob.delete();
    endtask

    // Advance the model across one clock edge using the currently driven inputs.
    task automatic model_step();
        bit fire;
        int m [A];
        int k;
        int ns0 [W];
        int ns1 [W];
        int nd  [W];
        int nst [W];
        if (!rst) begin
            model_reset();
            return;
        end
        fire = in_valid && m_in_ready();
        m = m_spec;
        k = 0;
        for (int i = 0; i < W; i++) begin
            ns0[i] = 0; ns1[i] = 0; nd[i] = 0; nst[i] = 0;
        end
        if (fire) begin
            // Rename lanes one after another against a running map copy.
            for (int i = 0; i < W; i++) begin
                int d;
                d = get_a(in_dst, i);
                ns0[i] = m[get_a(in_src0, i)];
                ns1[i] = m[get_a(in_src1, i)];
                if (in_lane_valid[i] && in_dst_we[i] && d != 0) begin
                    nd[i]  = ring[spec_used + k];
                    nst[i] = m[d];
                    m[d]   = nd[i];
                    k++;
                    rob.push_back(rob_t'{d, nd[i], nst[i]});
                end
            end
            spec_used += k;
            $display("rename: lv=%b dst_p=%0d/%0d stale_p=%0d/%0d free_before=%0d",
                     in_lane_valid, nd[0], nd[1], nst[0], nst[1], ring.size() - spec_used + k);
        end
        for (int i = 0; i < W; i++) begin
            if (commit_valid[i] && commit_we[i] && get_a(commit_dst, i) != 0) begin
                m_commit[get_a(commit_dst, i)] = get_p(commit_dst_p, i);
                void'(ring.pop_front());
                spec_used--;
                ring.push_back(get_p(commit_stale_p, i));
                if (rob.size() > 0) void'(rob.pop_front());
            end
        end
        if (recover) begin
            m_spec = m_commit;
            spec_used = 0;
            m_ov = 1'b0;
            rob.delete();
        end else if (fire) begin
            m_spec = m;
            m_ov = 1'b1;
            for (int i = 0; i < W; i++) begin
                m_lv[i] = int'(in_lane_valid[i]);
                m_s0[i] = ns0[i]; m_s1[i] = ns1[i]; m_d[i] = nd[i]; m_st[i] = nst[i];
            end
        end else if (out_ready) begin
            m_ov = 1'b0;
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic compare_all();
        chk("in_ready", 64'(in_ready), 64'(m_in_ready()));
        chk("free_count", 64'(free_count), 64'(ring.size() - spec_used));
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        if (m_ov) begin
            for (int i = 0; i < W; i++) begin
                chk($sformatf("lane_valid[%0d]", i), 64'(out_lane_valid[i]), 64'(m_lv[i]));
                chk($sformatf("src0_p[%0d]", i),  64'(get_p(out_src0_p, i)),  64'(m_s0[i]));
                chk($sformatf("src1_p[%0d]", i),  64'(get_p(out_src1_p, i)),  64'(m_s1[i]));
                chk($sformatf("dst_p[%0d]", i),   64'(get_p(out_dst_p, i)),   64'(m_d[i]));
                chk($sformatf("stale_p[%0d]", i), 64'(get_p(out_stale_p, i)), 64'(m_st[i]));
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        compare_all();
        model_step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive_idle();
        recover = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_lane_valid = '0; in_dst_we = '0; in_src0 = '0; in_src1 = '0; in_dst = '0;
        commit_valid = '0; commit_we = '0; commit_dst = '0;
        commit_dst_p = '0; commit_stale_p = '0;
    endtask

    task automatic set_lane(input int i, input bit v, input int s0, input int s1,
                            input int d, input bit we);
        in_lane_valid[i]    = v;
        in_src0[i*AW +: AW] = AW'(s0);
        in_src1[i*AW +: AW] = AW'(s1);
        in_dst[i*AW +: AW]  = AW'(d);
        in_dst_we[i]        = we;
    endtask

    task automatic set_commit(input int i, input int d, input int p, input int s);
        commit_valid[i]            = 1'b1;
        commit_we[i]               = 1'b1;
        commit_dst[i*AW +: AW]     = AW'(d);
        commit_dst_p[i*PW +: PW]   = PW'(p);
        commit_stale_p[i*PW +: PW] = PW'(s);
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b0;
        #1;
        chk("in_ready_during_reset", 64'(in_ready), 64'd0);
        cycle();
        rst = 1'b1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_free_count", 64'(free_count), 64'd32);
        chk("reset_out_dst_p", 64'(out_dst_p), 64'd0);
    endtask

    initial begin
        drive_idle();
        rst = 1'b0;
        @(posedge clk);
        #1;
        model_reset();

        // 1: forwarding inside a bundle
        do_reset();
        set_lane(0, 1, 2, 3, 1, 1);
        set_lane(1, 1, 1, 1, 4, 1);
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk("t1_src0_l0",  64'(get_p(out_src0_p, 0)),  64'd2);
        chk("t1_src1_l0",  64'(get_p(out_src1_p, 0)),  64'd3);
        chk("t1_dst_l0",   64'(get_p(out_dst_p, 0)),   64'd32);
        chk("t1_stale_l0", 64'(get_p(out_stale_p, 0)), 64'd1);
        chk("t1_src0_l1",  64'(get_p(out_src0_p, 1)),  64'd32);
        chk("t1_src1_l1",  64'(get_p(out_src1_p, 1)),  64'd32);
        chk("t1_dst_l1",   64'(get_p(out_dst_p, 1)),   64'd33);
        chk("t1_stale_l1", 64'(get_p(out_stale_p, 1)), 64'd4);
        chk("t1_free",     64'(free_count),            64'd30);

        // 2: exhaustion, then two frees
        do_reset();
        set_lane(0, 1, 1, 2, 1, 1);
        set_lane(1, 1, 3, 4, 2, 1);
        in_valid = 1'b1;
        repeat (16) cycle();
        chk("t2_dst_l0", 64'(get_p(out_dst_p, 0)), 64'd62);
        chk("t2_dst_l1", 64'(get_p(out_dst_p, 1)), 64'd63);
        chk("t2_free_empty", 64'(free_count), 64'd0);
        chk("t2_in_ready_empty", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        set_commit(0, 1, 32, 1);
        set_commit(1, 2, 33, 2);
        cycle();
        drive_idle();
        chk("t2_free_after_commit", 64'(free_count), 64'd2);
        chk("t2_in_ready_after_commit", 64'(in_ready), 64'd1);

        // 3: recover discards three unretired bundles
        do_reset();
        set_lane(0, 1, 1, 2, 5, 1);
        in_valid = 1'b1;
        repeat (3) cycle();
        in_valid = 1'b0;
        recover = 1'b1;
        cycle();
        recover = 1'b0;
        chk("t3_out_valid", 64'(out_valid), 64'd0);
        chk("t3_free", 64'(free_count), 64'd32);
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk("t3_dst", 64'(get_p(out_dst_p, 0)), 64'd32);
        chk("t3_stale", 64'(get_p(out_stale_p, 0)), 64'd5);

        // 4: recover in the same cycle as a commit
        do_reset();
        set_lane(0, 1, 1, 2, 7, 1);
        in_valid = 1'b1;
        cycle();
        set_lane(0, 1, 1, 2, 9, 1);
        cycle();
        in_valid = 1'b0;
        recover = 1'b1;
        set_commit(0, 7, 32, 7);
        cycle();
        drive_idle();
        chk("t4_free", 64'(free_count), 64'd32);
        set_lane(0, 1, 7, 0, 10, 1);
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk("t4_src0", 64'(get_p(out_src0_p, 0)), 64'd32);
        chk("t4_src1", 64'(get_p(out_src1_p, 0)), 64'd0);
        chk("t4_dst", 64'(get_p(out_dst_p, 0)), 64'd33);
        chk("t4_stale", 64'(get_p(out_stale_p, 0)), 64'd10);

        // 5: backpressure holds the slot and the pointers
        do_reset();
        out_ready = 1'b0;
        set_lane(0, 1, 2, 3, 1, 1);
        set_lane(1, 1, 1, 1, 4, 1);
        in_valid = 1'b1;
        cycle();
        set_lane(0, 1, 5, 6, 8, 1);
        set_lane(1, 1, 8, 9, 11, 1);
        for (int c = 0; c < 5; c++) begin
            cycle();
            chk("t5_out_valid", 64'(out_valid), 64'd1);
            chk("t5_dst_l0", 64'(get_p(out_dst_p, 0)), 64'd32);
            chk("t5_dst_l1", 64'(get_p(out_dst_p, 1)), 64'd33);
            chk("t5_src0_l1", 64'(get_p(out_src0_p, 1)), 64'd32);
            chk("t5_stale_l1", 64'(get_p(out_stale_p, 1)), 64'd4);
            chk("t5_in_ready", 64'(in_ready), 64'd0);
            chk("t5_free", 64'(free_count), 64'd30);
        end
        drive_idle();
        cycle();
        chk("t5_drained", 64'(out_valid), 64'd0);

        // 6: zero register never allocates
        do_reset();
        set_lane(0, 1, 0, 0, 0, 1);
        set_lane(1, 0, 0, 0, 0, 0);
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk("t6_out_valid", 64'(out_valid), 64'd1);
        chk("t6_src0", 64'(get_p(out_src0_p, 0)), 64'd0);
        chk("t6_src1", 64'(get_p(out_src1_p, 0)), 64'd0);
        chk("t6_dst", 64'(get_p(out_dst_p, 0)), 64'd0);
        chk("t6_stale", 64'(get_p(out_stale_p, 0)), 64'd0);
        chk("t6_free", 64'(free_count), 64'd32);

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int ncom;
            rst       = ($urandom_range(0, 299) != 0);
            recover   = ($urandom_range(0, 39) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < W; i++) begin
                set_lane(i, 1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
                         int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                         1'($urandom_range(0, 3) != 0));
            end
            ncom = 0;
            if ($urandom_range(0, 2) == 0) ncom = int'($urandom_range(0, W));
            if (ncom > rob.size()) ncom = rob.size();
            commit_valid = '0; commit_we = '0; commit_dst = '0;
            commit_dst_p = '0; commit_stale_p = '0;
            for (int j = 0; j < W; j++) begin
                if (j < ncom) begin
                    set_commit(j, rob[j].dst, rob[j].p, rob[j].stale);
                end else begin
                    // Ignored lane: valid without write enable.
                    commit_valid[j] = 1'($urandom_range(0, 1));
                    commit_dst[j*AW +: AW] = AW'($urandom_range(1, A-1));
                end
            end
            cycle();
        end
        drive_idle();
        rst = 1'b1;
        repeat (3) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rename_stage_nw.md
# rename_stage_nw

Parametrised N-wide register-rename stage between decode and dispatch. Maps architectural sources to physical registers and allocates new destinations from a circular free list, with intra-bundle dependency forwarding. Keeps a speculative and a committed map table; on `recover` it restores the speculative state from the committed state in one cycle. Results are held in a registered output slot with valid/ready backpressure.

## Interface
- `WIDTH`, default 2: rename/commit lanes per cycle.
- `ARCH_REGS`, default 32: architectural registers. Arch reg 0 is hardwired to phys 0.
- `PHYS_REGS`, default 64: physical registers. `FL_DEPTH = PHYS_REGS-ARCH_REGS` must be a power of two and at least `WIDTH`.
- Derived widths: `AW = $clog2(ARCH_REGS)`, `PW = $clog2(PHYS_REGS)`.

Ports (name, direction, width, meaning):
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-low reset.
- `recover`  in  1  flush; restore speculative state from the committed state.
- `in_valid`  in  1  a rename bundle is offered.
- `in_ready`  out  1  the bundle is accepted this cycle.
- `in_lane_valid`  in  WIDTH  per-lane valid.
- `in_src0`, `in_src1`, `in_dst`  in  WIDTH*AW  arch addresses; lane i is at bits [i*AW +: AW].
- `in_dst_we`  in  WIDTH  lane writes its destination.
- `out_valid`  out  1  the output slot holds a renamed bundle.
- `out_ready`  in  1  downstream consumes the slot.
- `out_lane_valid`  out  WIDTH  per-lane valid, passed through.
- `out_src0_p`, `out_src1_p`, `out_dst_p`, `out_stale_p`  out  WIDTH*PW  physical addresses.
- `commit_valid`, `commit_we`  in  WIDTH  per-lane retire.
- `commit_dst`  in  WIDTH*AW  retiring arch destination.
- `commit_dst_p`, `commit_stale_p`  in  WIDTH*PW  retiring new and stale physical registers.
- `free_count`  out  PW+1  speculative free-list occupancy.

## Operation
- **Free list:** circular buffer of `FL_DEPTH` entries with `spec_head`, `commit_head` and `tail`, each `log2(FL_DEPTH)+1` bits (the MSB is the wrap bit).
  - `free_count = tail - spec_head`, modulo 2^(log2(FL_DEPTH)+1).
  - Reset contents: entry k = `ARCH_REGS+k`. Reset pointers: heads 0, `tail` = `FL_DEPTH` (wrap bit set, so the list is full).
- **Maps:** `spec_map` and `commit_map`, each `ARCH_REGS` x PW. Reset to identity (i→i).
- **Allocating lane:** `in_lane_valid[i] & in_dst_we[i] & in_dst[i]!=0`. Allocating lanes take consecutive entries from `spec_head` in lane order.
- **Non-allocating lane:** `out_dst_p = 0`, `out_stale_p = 0`.
- **Source lookup:** arch 0 → phys 0. Otherwise use the newest lower-numbered allocating lane in the same bundle with a matching dst, and take its new phys. If there is none, use `spec_map`.
- **Stale lookup:** same forwarding rule applied to dst.
- **Handshakes:**
  - `in_ready = rst & !recover & free_count>=WIDTH & (!out_valid | out_ready)`.
  - Fire = `in_valid & in_ready`. On fire: capture results into the output slot, advance `spec_head` by the number of allocating lanes, and update `spec_map`. Within a bundle the last writer wins.
- **Commit:** per lane with `commit_valid & commit_we & commit_dst!=0`, in lane order:
  - `commit_map[dst] = commit_dst_p`.
  - Write `commit_stale_p` at `tail` and increment `tail`.
  - Increment `commit_head`.
- **Recover (cycle edge):**
  - `spec_map` ← `commit_map`, including this cycle's commits.
  - `spec_head` ← `commit_head`, including this cycle's commits.
  - `out_valid` ← 0.
  - Tail pushes from commit still apply.
- **Reset (any cycle, including mid-bundle):** restores all reset values and drops the output slot.

## Timing
- Rename latency is 1 cycle: a bundle accepted at edge n is visible at the outputs after edge n.
- While `out_valid & !out_ready`, all `out_*` hold stable.
- Same-cycle commit and allocation: count = old + frees − allocations, with no bypass of this cycle's frees into `in_ready`.
- A commit's stale reg is allocatable from the next cycle.
- Reset values: `out_valid=0`, all `out_*` = 0, `in_ready=0` during reset, `free_count=FL_DEPTH`.
- Wrap-around: pointers wrap modulo 2·`FL_DEPTH`. Full is `free_count==FL_DEPTH`; empty is `free_count==0`.

## Test plan
1. **Forwarding.** After reset, bundle lane0 r1=r2+r3, lane1 r4=r1+r1 → lane0 src 2/3, dst 32, stale 1; lane1 src 32/32, dst 33, stale 4; `free_count` 30.
2. **Exhaustion.** Fire 16 two-writer bundles → dsts 32..63, `free_count` 0, `in_ready` 0. One cycle committing two stales → `free_count` 2 and `in_ready` 1 the next cycle.
3. **Recover.** After 3 unretired bundles, pulse `recover` → `out_valid` 0, `free_count` 32. Next bundle writing r5 gets dst 32 and stale 5.
4. **Recover with commit.** Same cycle as `recover`, commit r7→32 (stale 7) → afterwards r7 sources phys 32, the next allocation gets 33, and 7 is appended at the tail.
5. **Backpressure.** Hold `out_ready` low for 5 cycles → outputs unchanged, `in_ready` 0, no pointer movement.
6. **Zero register.** A bundle writing r0 with source r0 → src 0, dst 0, stale 0, no allocation.
